decode_stage: RTL and testbench

- Instruction-decode pipeline stage sitting directly upstream of register_file and downstream of the fetch stage.
- Holds one fetched instruction in its stage register and drives the register-file read addresses from it.
- Resolves operands using EX/MEM/WB bypass networks and stalls on load-use hazards.
- Hands the decoded bundle to execute under a valid/allowin handshake.

---
 rtl/decode_stage.sv | 137 +++++++++++++
 tb/tb_decode_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: holds one fetched instruction, drives
// register-file read addresses, resolves operands through EX/MEM/WB bypass,
// stalls on load-use hazards and hands off to execute via valid/allowin.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instruction,
  output logic        decode_allowin,
  input  logic        flush,
  output logic [4:0]  read_address_1,
  input  logic [31:0] read_data_1,
  output logic [4:0]  read_address_2,
  input  logic [31:0] read_data_2,
  input  logic        execute_valid,
  input  logic        execute_write_enabled,
  input  logic        execute_is_load,
  input  logic [4:0]  execute_write_address,
  input  logic [31:0] execute_write_data,
  input  logic        memory_valid,
  input  logic        memory_write_enabled,
  input  logic [4:0]  memory_write_address,
  input  logic [31:0] memory_write_data,
  input  logic        writeback_valid,
  input  logic        writeback_write_enabled,
  input  logic [4:0]  writeback_write_address,
  input  logic [31:0] writeback_write_data,
  input  logic        execute_allowin,
  output logic        decode_valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic [31:0] operand_1,
  output logic [31:0] operand_2,
  output logic [4:0]  destination_out
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [5:0]  opcode;
  logic        ex_hit_enable;
  logic        mem_hit_enable;
  logic        wb_hit_enable;
  logic        load_use;
  logic        ready_go;

  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign opcode = instr_q[31:26];

  assign ex_hit_enable  = execute_valid & execute_write_enabled;
  assign mem_hit_enable = memory_valid & memory_write_enabled;
  assign wb_hit_enable  = writeback_valid & writeback_write_enabled;

  // Priority bypass: r0 is hard zero, then youngest producer wins.
  function automatic logic [31:0] resolve(input logic [4:0]  src,
                                          input logic [31:0] rf_data,
                                          input logic        ex_en,
                                          input logic [4:0]  ex_addr,
                                          input logic [31:0] ex_data,
                                          input logic        mem_en,
                                          input logic [4:0]  mem_addr,
                                          input logic [31:0] mem_data,
                                          input logic        wb_en,
                                          input logic [4:0]  wb_addr,
                                          input logic [31:0] wb_data);
    logic [31:0] r;
    if (src == 5'd0)                      r = '0;
    else if (ex_en && ex_addr == src)     r = ex_data;
    else if (mem_en && mem_addr == src)   r = mem_data;
    else if (wb_en && wb_addr == src)     r = wb_data;
    else                                  r = rf_data;
    return r;
  endfunction

  // Load-use hazard: both rs and rt are treated as sources.
  always_comb begin
    load_use = valid_q && ex_hit_enable && execute_is_load &&
               (execute_write_address != 5'd0) &&
               ((execute_write_address == rs) || (execute_write_address == rt));
    ready_go         = !load_use;
    decode_allowin   = !valid_q || (ready_go && execute_allowin);
    decode_valid_out = valid_q && ready_go;
  end

  // Operand resolution from the held instruction plus bypass inputs.
  always_comb begin
    operand_1 = resolve(rs, read_data_1,
                        ex_hit_enable, execute_write_address, execute_write_data,
                        mem_hit_enable, memory_write_address, memory_write_data,
                        wb_hit_enable, writeback_write_address, writeback_write_data);
    operand_2 = resolve(rt, read_data_2,
                        ex_hit_enable, execute_write_address, execute_write_data,
                        mem_hit_enable, memory_write_address, memory_write_data,
                        wb_hit_enable, writeback_write_address, writeback_write_data);
  end

  // Destination register decode: R-type -> rd, JAL -> r31, else rt.
  always_comb begin
    destination_out = rt;
    case (opcode)
      6'b000000: destination_out = instr_q[15:11];
      6'b000011: destination_out = 5'd31;
      default:   destination_out = rt;
    endcase
  end

  // Stage register; flush kills valid but leaves pc/instruction untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      if (flush)
        valid_q <= 1'b0;
      else if (decode_allowin)
        valid_q <= fetch_valid;
      if (fetch_valid && decode_allowin && !flush) begin
        pc_q    <= fetch_pc;
        instr_q <= fetch_instruction;
      end
    end
  end

  assign read_address_1  = rs;
  assign read_address_2  = rt;
  assign pc_out          = pc_q;
  assign instruction_out = instr_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_decode_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clock;
  logic        reset_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instruction;
  logic        decode_allowin;
  logic        flush;
  logic [4:0]  read_address_1;
  logic [31:0] read_data_1;
  logic [4:0]  read_address_2;
  logic [31:0] read_data_2;
  logic        execute_valid;
  logic        execute_write_enabled;
  logic        execute_is_load;
  logic [4:0]  execute_write_address;
  logic [31:0] execute_write_data;
  logic        memory_valid;
  logic        memory_write_enabled;
  logic [4:0]  memory_write_address;
  logic [31:0] memory_write_data;
  logic        writeback_valid;
  logic        writeback_write_enabled;
  logic [4:0]  writeback_write_address;
  logic [31:0] writeback_write_data;
  logic        execute_allowin;
  logic        decode_valid_out;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic [4:0]  destination_out;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  decode_stage #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instruction(fetch_instruction),
    .decode_allowin(decode_allowin), .flush(flush),
    .read_address_1(read_address_1), .read_data_1(read_data_1),
    .read_address_2(read_address_2), .read_data_2(read_data_2),
    .execute_valid(execute_valid), .execute_write_enabled(execute_write_enabled),
    .execute_is_load(execute_is_load), .execute_write_address(execute_write_address),
    .execute_write_data(execute_write_data),
    .memory_valid(memory_valid), .memory_write_enabled(memory_write_enabled),
    .memory_write_address(memory_write_address), .memory_write_data(memory_write_data),
    .writeback_valid(writeback_valid), .writeback_write_enabled(writeback_write_enabled),
    .writeback_write_address(writeback_write_address), .writeback_write_data(writeback_write_data),
    .execute_allowin(execute_allowin), .decode_valid_out(decode_valid_out),
    .pc_out(pc_out), .instruction_out(instruction_out),
    .operand_1(operand_1), .operand_2(operand_2), .destination_out(destination_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic exp_stall();
    logic [4:0] s1, s2;
    s1 = m_instr[25:21];
    s2 = m_instr[20:16];
    return m_valid && execute_valid && execute_write_enabled && execute_is_load &&
           execute_write_address != 5'd0 &&
           (execute_write_address == s1 || execute_write_address == s2);
  endfunction

  function automatic logic [31:0] exp_operand(input logic [4:0] src, input logic [31:0] rf);
    logic        en  [3];
    logic [4:0]  adr [3];
    logic [31:0] dat [3];
    en[0] = execute_valid && execute_write_enabled;     adr[0] = execute_write_address;   dat[0] = execute_write_data;
    en[1] = memory_valid && memory_write_enabled;       adr[1] = memory_write_address;    dat[1] = memory_write_data;
    en[2] = writeback_valid && writeback_write_enabled; adr[2] = writeback_write_address; dat[2] = writeback_write_data;
    if (src == 5'd0) return 32'd0;
    for (int i = 0; i < 3; i++)
      if (en[i] && adr[i] == src) return dat[i];
    return rf;
  endfunction

  function automatic logic [4:0] exp_dest();
    if (m_instr[31:26] == 6'd0) return m_instr[15:11];
    if (m_instr[31:26] == 6'd3) return 5'd31;
    return m_instr[20:16];
  endfunction

  function automatic logic exp_allowin();
    return !m_valid || (!exp_stall() && execute_allowin);
  endfunction

  task automatic model_update();
    logic take;
    take = exp_allowin();
    if (!reset_n) begin
      m_valid = 1'b0; m_pc = RST_PC; m_instr = 32'd0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (take) begin
      m_valid = fetch_valid;
      if (fetch_valid) begin
        m_pc    = fetch_pc;
        m_instr = fetch_instruction;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    fetch_valid = 0; fetch_pc = 0; fetch_instruction = 0; flush = 0;
    read_data_1 = 0; read_data_2 = 0;
    execute_valid = 0; execute_write_enabled = 0; execute_is_load = 0;
    execute_write_address = 0; execute_write_data = 0;
    memory_valid = 0; memory_write_enabled = 0; memory_write_address = 0; memory_write_data = 0;
    writeback_valid = 0; writeback_write_enabled = 0; writeback_write_address = 0;
    writeback_write_data = 0; execute_allowin = 0;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    m_valid = 0; m_pc = RST_PC; m_instr = 0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (decode_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", decode_valid_out); end
    checks++; if (pc_out !== RST_PC) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, RST_PC); end
    checks++; if (instruction_out !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", instruction_out); end
    checks++; if (decode_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b want 1", decode_allowin); end
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_basic();
    fetch_valid = 1; fetch_pc = 32'h100; fetch_instruction = 32'h012A_4020; execute_allowin = 1;
    read_data_1 = 32'h1111_1111; read_data_2 = 32'h2222_2222;
    tick();
    fetch_valid = 0; execute_allowin = 0;
    #1;
    checks++; if (decode_valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", decode_valid_out); end
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL basic_pc got %h want 100", pc_out); end
    checks++; if (read_address_1 !== 5'd9) begin errors++; $display("FAIL basic_ra1 got %0d want 9", read_address_1); end
    checks++; if (read_address_2 !== 5'd10) begin errors++; $display("FAIL basic_ra2 got %0d want 10", read_address_2); end
    checks++; if (destination_out !== 5'd8) begin errors++; $display("FAIL basic_dest got %0d want 8", destination_out); end
    checks++; if (operand_1 !== 32'h1111_1111) begin errors++; $display("FAIL basic_op1 got %h want 11111111", operand_1); end
    checks++; if (operand_2 !== 32'h2222_2222) begin errors++; $display("FAIL basic_op2 got %h want 22222222", operand_2); end
  endtask

  task automatic test_bypass();
    execute_valid = 1; execute_write_enabled = 1; execute_write_address = 9; execute_write_data = 32'hAAAA;
    memory_valid = 1; memory_write_enabled = 1; memory_write_address = 9; memory_write_data = 32'hBBBB;
    writeback_valid = 1; writeback_write_enabled = 1; writeback_write_address = 9; writeback_write_data = 32'hCCCC;
    #1;
    checks++; if (operand_1 !== 32'hAAAA) begin errors++; $display("FAIL bypass_ex got %h want aaaa", operand_1); end
    checks++; if (operand_2 !== 32'h2222_2222) begin errors++; $display("FAIL bypass_rt got %h want 22222222", operand_2); end
    execute_valid = 0; #1;
    checks++; if (operand_1 !== 32'hBBBB) begin errors++; $display("FAIL bypass_mem got %h want bbbb", operand_1); end
    memory_write_enabled = 0; #1;
    checks++; if (operand_1 !== 32'hCCCC) begin errors++; $display("FAIL bypass_wb got %h want cccc", operand_1); end
    writeback_valid = 0; #1;
    checks++; if (operand_1 !== 32'h1111_1111) begin errors++; $display("FAIL bypass_rf got %h want 11111111", operand_1); end
    @(negedge clock);
    clear_inputs();
    read_data_1 = 32'h1111_1111; read_data_2 = 32'h2222_2222;
  endtask

  task automatic test_load_use();
    fetch_valid = 1; fetch_pc = 32'h200; fetch_instruction = 32'h0000_0000; execute_allowin = 1;
    execute_valid = 1; execute_write_enabled = 1; execute_is_load = 1; execute_write_address = 10;
    #1;
    checks++; if (decode_valid_out !== 1'b0) begin errors++; $display("FAIL lu_valid got %b want 0", decode_valid_out); end
    checks++; if (decode_allowin !== 1'b0) begin errors++; $display("FAIL lu_allowin got %b want 0", decode_allowin); end
    tick();
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL lu_hold_pc got %h want 100", pc_out); end
    execute_valid = 0;
    memory_valid = 1; memory_write_enabled = 1; memory_write_address = 10; memory_write_data = 32'h1234;
    #1;
    checks++; if (decode_valid_out !== 1'b1) begin errors++; $display("FAIL lu_release got %b want 1", decode_valid_out); end
    checks++; if (operand_2 !== 32'h1234) begin errors++; $display("FAIL lu_op2 got %h want 1234", operand_2); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reg0();
    fetch_valid = 1; fetch_pc = 32'h300; fetch_instruction = 32'h000A_4020; execute_allowin = 1;
    read_data_2 = 32'h5555_0000;
    tick();
    fetch_valid = 0; execute_allowin = 0;
    execute_valid = 1; execute_write_enabled = 1; execute_is_load = 1; execute_write_address = 0; execute_write_data = '1;
    memory_valid = 1; memory_write_enabled = 1; memory_write_address = 0; memory_write_data = '1;
    writeback_valid = 1; writeback_write_enabled = 1; writeback_write_address = 0; writeback_write_data = '1;
    #1;
    checks++; if (operand_1 !== 32'd0) begin errors++; $display("FAIL r0_op1 got %h want 0", operand_1); end
    checks++; if (decode_valid_out !== 1'b1) begin errors++; $display("FAIL r0_nostall got %b want 1", decode_valid_out); end
    checks++; if (operand_2 !== 32'h5555_0000) begin errors++; $display("FAIL r0_op2 got %h want 55550000", operand_2); end
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_backpressure_flush();
    fetch_valid = 1; fetch_pc = 32'h400; fetch_instruction = 32'h2508_0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (decode_allowin !== 1'b0) begin errors++; $display("FAIL bp_allowin[%0d] got %b want 0", i, decode_allowin); end
      checks++; if (pc_out !== 32'h300 || decode_valid_out !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got %h/%b want 300/1", i, pc_out, decode_valid_out); end
      tick();
    end
    flush = 1; fetch_pc = 32'h500; fetch_instruction = 32'h2508_0002; execute_allowin = 1;
    tick();
    clear_inputs();
    #1;
    checks++; if (decode_valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", decode_valid_out); end
    checks++; if (pc_out !== 32'h300 || instruction_out !== 32'h000A_4020) begin errors++; $display("FAIL flush_nolatch got %h/%h want 300/000a4020", pc_out, instruction_out); end
    @(negedge clock);
  endtask

  task automatic test_dest();
    execute_allowin = 1; fetch_valid = 1; fetch_pc = 32'h600; fetch_instruction = 32'h0C00_0040;
    tick();
    #1;
    checks++; if (destination_out !== 5'd31) begin errors++; $display("FAIL dest_jal got %0d want 31", destination_out); end
    fetch_pc = 32'h604; fetch_instruction = 32'h2508_FFFF;
    @(negedge clock);
    tick();
    fetch_valid = 0; execute_allowin = 0;
    #1;
    checks++; if (destination_out !== 5'd8) begin errors++; $display("FAIL dest_addiu got %0d want 8", destination_out); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_stall();
    execute_allowin = 1;
    execute_valid = 1; execute_write_enabled = 1; execute_is_load = 1; execute_write_address = 8;
    #1;
    checks++; if (decode_valid_out !== 1'b0 || pc_out !== 32'h604) begin errors++; $display("FAIL ms_stall got %b/%h want 0/604", decode_valid_out, pc_out); end
    #1;
    reset_n = 0;
    m_valid = 0; m_pc = RST_PC; m_instr = 0;
    #1;
    checks++; if (decode_valid_out !== 1'b0) begin errors++; $display("FAIL ms_valid got %b want 0", decode_valid_out); end
    checks++; if (pc_out !== RST_PC) begin errors++; $display("FAIL ms_pc got %h want %h", pc_out, RST_PC); end
    @(negedge clock);
    clear_inputs();
    reset_n = 1;
  endtask

  // ---------------- randomized traffic ----------------
  task automatic test_random();
    logic [5:0] opc;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0: opc = 6'd0;
        1: opc = 6'd3;
        default: opc = 6'($urandom_range(4, 63));
      endcase
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_pc = $urandom;
      fetch_instruction = {opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      flush = ($urandom_range(0, 15) == 0);
      execute_allowin = ($urandom_range(0, 3) != 0);
      read_data_1 = $urandom; read_data_2 = $urandom;
      execute_valid = $urandom_range(0, 1); execute_write_enabled = $urandom_range(0, 1);
      execute_is_load = $urandom_range(0, 1); execute_write_address = 5'($urandom_range(0, 3));
      execute_write_data = $urandom;
      memory_valid = $urandom_range(0, 1); memory_write_enabled = $urandom_range(0, 1);
      memory_write_address = 5'($urandom_range(0, 3)); memory_write_data = $urandom;
      writeback_valid = $urandom_range(0, 1); writeback_write_enabled = $urandom_range(0, 1);
      writeback_write_address = 5'($urandom_range(0, 3)); writeback_write_data = $urandom;
      #1;
      checks++; if (decode_valid_out !== (m_valid && !exp_stall())) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", n, decode_valid_out, m_valid && !exp_stall()); end
      checks++; if (decode_allowin !== exp_allowin()) begin errors++; $display("FAIL rnd_allowin[%0d] got %b want %b", n, decode_allowin, exp_allowin()); end
      checks++; if (pc_out !== m_pc || instruction_out !== m_instr) begin errors++; $display("FAIL rnd_reg[%0d] got %h/%h want %h/%h", n, pc_out, instruction_out, m_pc, m_instr); end
      checks++; if (read_address_1 !== m_instr[25:21] || read_address_2 !== m_instr[20:16]) begin errors++; $display("FAIL rnd_ra[%0d] got %0d/%0d want %0d/%0d", n, read_address_1, read_address_2, m_instr[25:21], m_instr[20:16]); end
      if (m_valid && !exp_stall()) begin
        checks++; if (operand_1 !== exp_operand(m_instr[25:21], read_data_1)) begin errors++; $display("FAIL rnd_op1[%0d] got %h want %h", n, operand_1, exp_operand(m_instr[25:21], read_data_1)); end
        checks++; if (operand_2 !== exp_operand(m_instr[20:16], read_data_2)) begin errors++; $display("FAIL rnd_op2[%0d] got %h want %h", n, operand_2, exp_operand(m_instr[20:16], read_data_2)); end
      end
      checks++; if (destination_out !== exp_dest()) begin errors++; $display("FAIL rnd_dest[%0d] got %0d want %0d", n, destination_out, exp_dest()); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_load_use();
    test_reg0();
    test_backpressure_flush();
    test_dest();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
